// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: paces the FFT column pipeline with a periodic load strobe,
// tracks slot occupancy, and stalls the whole pipeline under output backpressure.
module fft_stage_sequencer #(
  parameter int NUM_STAGES   = 5,
  parameter int STAGE_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  flush,
  output logic                  stage_adv,
  output logic [NUM_STAGES:0]   slot_valid,
  output logic                  busy,
  output logic [CNT_W-1:0]      frames_in,
  output logic [CNT_W-1:0]      frames_out
);
  localparam int CW = STAGE_CYCLES > 1 ? $clog2(STAGE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STAGE_CYCLES - 1);
  logic [CW-1:0]       cnt;
  logic                taken;
  logic                stall;
  logic [NUM_STAGES:0] next_sv;
  assign out_valid = reset & slot_valid[NUM_STAGES] & ~taken;
  assign stall     = out_valid & ~out_ready;
  assign stage_adv = reset & ~flush & (cnt == LAST) & ~stall;
  assign in_ready  = stage_adv;
  assign busy      = |slot_valid;
  assign next_sv   = {slot_valid[NUM_STAGES-1:0], in_valid};
  // An empty pipeline parks at the terminal count so a new frame is taken with no wait.
  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_valid <= '0;
      taken      <= 1'b0;
      cnt        <= LAST;
      frames_in  <= '0;
      frames_out <= '0;
    end else if (flush) begin
      slot_valid <= '0;
      taken      <= 1'b0;
      cnt        <= LAST;
    end else begin
      if (stage_adv) begin
        slot_valid <= next_sv;
        taken      <= 1'b0;
        cnt        <= next_sv == '0 ? LAST : '0;
      end else begin
        taken <= taken | (out_valid & out_ready);
        cnt   <= cnt < LAST ? cnt + CW'(1) : cnt;
      end
      frames_in  <= frames_in + CNT_W'(in_valid & stage_adv);
      frames_out <= frames_out + CNT_W'(out_valid & out_ready);
    end
  end
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: directed checks of pacing, latency, backpressure, flush, reset and counter wrap.
module tb_fft_stage_sequencer;
  logic       clk = 0, reset = 0, in_valid = 0, out_ready = 0, flush = 0;
  logic       in_ready, out_valid, stage_adv, busy;
  logic [5:0] slot_valid;
  logic [3:0] frames_in, frames_out;
  int         n_checks = 0, n_fail = 0;
  fft_stage_sequencer #(.NUM_STAGES(5), .STAGE_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .stage_adv(stage_adv), .slot_valid(slot_valid), .busy(busy),
    .frames_in(frames_in), .frames_out(frames_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Leaves the bench at the start of the first cycle with reset released.
  task automatic do_reset();
    reset = 0; in_valid = 0; flush = 0; out_ready = 1;
    step();
    #1;
    check("rst_adv", stage_adv, 0);
    check("rst_ready", in_ready, 0);
    check("rst_ov", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sv", slot_valid, 0);
    check("rst_fin", frames_in, 0);
    check("rst_fout", frames_out, 0);
    check("rst_cnt", dut.cnt, 3);
    step();
    reset = 1;
  endtask
  initial begin
    do_reset();
    for (int t = 0; t <= 30; t++) begin
      in_valid = (t == 0); out_ready = 1;
      #1;
      check("single_adv", stage_adv, (t % 4 == 0) || t > 24);
      check("single_ov", out_valid, t == 21);
      check("single_s5", slot_valid[5], t >= 21 && t <= 24);
      check("single_busy", busy, t >= 1 && t <= 24);
      step();
    end
    check("single_fin", frames_in, 1);
    check("single_fout", frames_out, 1);
    do_reset();
    for (int t = 0; t <= 66; t++) begin
      in_valid = (t <= 36); out_ready = 1;
      #1;
      check("stream_adv", stage_adv, (t <= 60) ? (t % 4 == 0) : 1);
      check("stream_ov", out_valid, t >= 21 && t <= 57 && (t - 21) % 4 == 0);
      step();
    end
    check("stream_fin", frames_in, 10);
    check("stream_fout", frames_out, 10);
    do_reset();
    for (int t = 0; t <= 31; t++) begin
      in_valid = (t == 0 || t == 4 || t == 8); out_ready = !(t >= 21 && t <= 29);
      #1;
      if (t >= 21 && t <= 29) begin
        check("bp_adv", stage_adv, 0);
        check("bp_ov", out_valid, 1);
        check("bp_sv", slot_valid, 6'b111000);
      end
      if (t >= 24 && t <= 30) check("bp_cnt", dut.cnt, 3);
      if (t == 30) begin
        check("bp_release_adv", stage_adv, 1);
        check("bp_release_ov", out_valid, 1);
        check("bp_fout_hold", frames_out, 0);
      end
      if (t == 31) begin
        check("bp_after_sv", slot_valid, 6'b110000);
        check("bp_after_ov", out_valid, 1);
        check("bp_after_fout", frames_out, 1);
      end
      step();
    end
    do_reset();
    for (int t = 0; t <= 45; t++) begin
      in_valid = (t == 0 || t == 8 || t == 16 || t == 17); out_ready = 1; flush = (t == 17);
      #1;
      if (t == 17) begin
        check("flush_pre_sv", slot_valid, 6'b010101);
        check("flush_ready", in_ready, 0);
      end
      if (t == 18) begin
        check("flush_sv", slot_valid, 0);
        check("flush_busy", busy, 0);
        check("flush_ready_after", in_ready, 1);
        check("flush_fin", frames_in, 3);
      end
      if (t >= 18) check("flush_ov", out_valid, 0);
      step();
    end
    flush = 0;
    check("flush_fout", frames_out, 0);
    do_reset();
    for (int t = 0; t <= 40; t++) begin
      reset = (t != 14); in_valid = (t <= 12 && t % 4 == 0) || t == 15; out_ready = 1;
      #1;
      if (t == 13) check("mid_pre_sv", slot_valid, 6'b001111);
      if (t == 14) begin
        check("mid_adv", stage_adv, 0);
        check("mid_ov", out_valid, 0);
      end
      if (t == 15) begin
        check("mid_sv", slot_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_fin", frames_in, 0);
        check("mid_fout", frames_out, 0);
        check("mid_ready", in_ready, 1);
      end
      if (t >= 15) check("mid_ov_new", out_valid, t == 36);
      step();
    end
    do_reset();
    for (int t = 0; t <= 95; t++) begin
      in_valid = (t <= 64); out_ready = 1;
      #1;
      if (t == 61) check("wrap_fin16", frames_in, 0);
      step();
    end
    check("wrap_fin", frames_in, 1);
    check("wrap_fout", frames_out, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
